// File: rtl/pattern_detect_sched.sv
// Round-robin scheduler time-sharing one "0-then-1" Mealy detector among NREQ serial requesters.
// Optional idle-bit watchdog enabled by defining PDS_TIMEOUT_EN.
module pattern_detect_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned CNTW        = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         bit_in,
  input  logic [NREQ-1:0]         bit_valid,
  input  logic [NREQ-1:0]         bit_last,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNTW-1:0]         match_count,
  output logic                    aborted
);

  localparam int unsigned IDW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam logic DET_S0 = 1'b0;
  localparam logic DET_S1 = 1'b1;

  if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("pattern_detect_sched: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  logic [1:0]      state, state_d;
  logic [IDW-1:0]  rr_ptr, rr_ptr_d;
  logic [IDW-1:0]  sel, sel_d;
  logic            det, det_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic [NREQ-1:0] gnt_d;
  logic            busy_d;
  logic            done_d;
  logic [IDW-1:0]  done_id_d;
  logic [CNTW-1:0] match_count_d;
  logic            aborted_d;

  logic [IDW:0]    pick;
  logic            cur_valid, cur_bit, cur_last, cur_req;

`ifdef PDS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd, wd_d;
`endif

  // First requester at or after ptr, with wrap; result is {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] ptr);
    logic [IDW:0] res;
    int unsigned  j;
    res = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + (NREQ - 1 - k);
      if (j >= NREQ) j = j - NREQ;
      if (r[IDW'(j)]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  assign pick      = rr_pick(req, rr_ptr);
  assign cur_valid = bit_valid[sel];
  assign cur_bit   = bit_in[sel];
  assign cur_last  = bit_last[sel];
  assign cur_req   = req[sel];

  always_comb begin
    state_d       = state;
    rr_ptr_d      = rr_ptr;
    sel_d         = sel;
    det_d         = det;
    cnt_d         = cnt;
    gnt_d         = gnt;
    busy_d        = busy;
    done_d        = 1'b0;
    done_id_d     = done_id;
    match_count_d = match_count;
    aborted_d     = aborted;
`ifdef PDS_TIMEOUT_EN
    wd_d          = wd;
`endif

    case (state)
      ST_IDLE: begin
        if (pick[IDW]) begin
          state_d = ST_STREAM;
          sel_d   = pick[IDW-1:0];
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick[IDW-1:0];
          cnt_d   = '0;
          det_d   = DET_S0;
          busy_d  = 1'b1;
`ifdef PDS_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      ST_STREAM: begin
        // Only the granted channel is observed; invalid cycles hold the detector.
        if (cur_valid) begin
          det_d = cur_bit ? DET_S0 : DET_S1;
          if (det == DET_S1 && cur_bit && cnt != '1) cnt_d = cnt + CNTW'(1);
        end
`ifdef PDS_TIMEOUT_EN
        wd_d = cur_valid ? '0 : wd + TW'(1);
`endif
        done_id_d     = sel;
        match_count_d = cnt_d;
        if (cur_valid && cur_last) begin
          state_d   = ST_REPORT;
          done_d    = 1'b1;
          aborted_d = 1'b0;
        end else if (!cur_req) begin
          state_d   = ST_REPORT;
          done_d    = 1'b1;
          aborted_d = 1'b1;
`ifdef PDS_TIMEOUT_EN
        end else if (!cur_valid && wd == TW'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_REPORT;
          done_d    = 1'b1;
          aborted_d = 1'b1;
`endif
        end else begin
          done_id_d     = done_id;
          match_count_d = match_count;
        end
      end

      ST_REPORT: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      sel         <= '0;
      det         <= DET_S0;
      cnt         <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      match_count <= '0;
      aborted     <= 1'b0;
`ifdef PDS_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      sel         <= sel_d;
      det         <= det_d;
      cnt         <= cnt_d;
      gnt         <= gnt_d;
      busy        <= busy_d;
      done        <= done_d;
      done_id     <= done_id_d;
      match_count <= match_count_d;
      aborted     <= aborted_d;
`ifdef PDS_TIMEOUT_EN
      wd          <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_pattern_detect_sched.sv
// Scoreboard bench for pattern_detect_sched: a CNTW=8 instance plus a CNTW=2 instance for saturation.
module tb_pattern_detect_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req2, bit_in, bit_valid, bit_last;

  logic [3:0] gnt, gnt2;
  logic       busy, busy2, done, done2, aborted, aborted2;
  logic [1:0] done_id, done_id2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  always #5 clk = ~clk;

  pattern_detect_sched #(.NREQ(4), .CNTW(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_last(bit_last), .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .match_count(match_count), .aborted(aborted));

  pattern_detect_sched #(.NREQ(4), .CNTW(2), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_last(bit_last), .gnt(gnt2), .busy(busy2), .done(done2), .done_id(done_id2),
    .match_count(match_count2), .aborted(aborted2));

  typedef struct {int id; int cnt; bit abrt;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic push_exp(input int id, input int cnt, input bit abrt);
    exp_t e;
    e.id = id; e.cnt = cnt; e.abrt = abrt;
    sb.push_back(e);
  endtask

  task automatic send_bit(input int ch, input bit b, input bit v, input bit l);
    bit_in[ch] = b; bit_valid[ch] = v; bit_last[ch] = l;
    @(posedge clk); #1;
    bit_in[ch] = 1'b0; bit_valid[ch] = 1'b0; bit_last[ch] = 1'b0;
  endtask

  task automatic wait_grant(input bit inst2, input int ch);
    logic [3:0] g, e;
    bit got = 1'b0;
    g = '0;
    e = 4'b0001 << ch;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g = inst2 ? gnt2 : gnt;
      if (g != 4'b0000) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got || g !== e) begin
      n_err++;
      $display("FAIL grant inst%0d: gnt=%b required %b", inst2, g, e);
    end
  endtask

  task automatic wait_done(input bit inst2);
    exp_t e;
    bit got = 1'b0;
    int id, cnt;
    bit ab;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((inst2 ? done2 : done) === 1'b1) begin got = 1'b1; break; end
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty inst%0d: done seen=%0d with no expectation", inst2, got);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL done_timeout inst%0d: no done, required id=%0d", inst2, e.id);
      return;
    end
    id  = inst2 ? int'(done_id2) : int'(done_id);
    cnt = inst2 ? int'(match_count2) : int'(match_count);
    ab  = inst2 ? aborted2 : aborted;
    if (id !== e.id) begin
      n_err++; $display("FAIL done_id inst%0d: got %0d required %0d", inst2, id, e.id);
    end
    n_cmp++;
    if (cnt !== e.cnt) begin
      n_err++; $display("FAIL match_count inst%0d: got %0d required %0d", inst2, cnt, e.cnt);
    end
    n_cmp++;
    if (ab !== e.abrt) begin
      n_err++; $display("FAIL aborted inst%0d: got %0d required %0d", inst2, ab, e.abrt);
    end
    @(negedge clk);
    n_cmp++;
    if ((inst2 ? {done2, gnt2} : {done, gnt}) !== 5'b0) begin
      n_err++;
      $display("FAIL done_pulse inst%0d: done/gnt=%b required 00000", inst2,
               inst2 ? {done2, gnt2} : {done, gnt});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; req2 = '0; bit_in = '0; bit_valid = '0; bit_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({gnt, busy, done, done_id, match_count, aborted} !== 17'b0) begin
      n_err++;
      $display("FAIL reset_main: outputs=%h required 0", {gnt, busy, done, done_id, match_count, aborted});
    end
    n_cmp++;
    if ({gnt2, busy2, done2, done_id2, match_count2, aborted2} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_inst2: outputs=%h required 0", {gnt2, busy2, done2, done_id2, match_count2, aborted2});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    req = 4'b0001;
    @(posedge clk); #1;
    n_cmp++;
    if ({gnt, busy} !== 5'b00011) begin
      n_err++; $display("FAIL basic_grant: gnt/busy=%b required 00011", {gnt, busy});
    end
    push_exp(0, 2, 1'b0);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b1, 1'b1);
    req = '0;
    wait_done(1'b0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req = 4'b0001;
    wait_grant(1'b0, 0);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (match_count !== 8'd2) begin
      n_err++; $display("FAIL held_count: got %0d required 2", match_count);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, busy, done, match_count} !== 14'b0) begin
      n_err++; $display("FAIL async_reset: gnt/busy/done/count=%h required 0", {gnt, busy, done, match_count});
    end
    req = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(1'b0, k % 4);
      push_exp(k % 4, 0, 1'b0);
      send_bit(k % 4, 1'b0, 1'b1, 1'b1);
      if (k == 4) req = '0;
      wait_done(1'b0);
    end
  endtask

  task automatic test_gap();
    @(posedge clk); #1;
    req = 4'b0100;
    wait_grant(1'b0, 2);
    push_exp(2, 1, 1'b0);
    send_bit(2, 1'b0, 1'b1, 1'b0);
    // Noise on an ungranted channel must be ignored.
    bit_valid[3] = 1'b1; bit_last[3] = 1'b1; bit_in[3] = 1'b1;
    for (int k = 0; k < 3; k++) send_bit(2, 1'b1, 1'b0, 1'b0);
    bit_valid[3] = 1'b0; bit_last[3] = 1'b0; bit_in[3] = 1'b0;
    send_bit(2, 1'b1, 1'b1, 1'b1);
    req = '0;
    wait_done(1'b0);
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    req2 = 4'b0001;
    wait_grant(1'b1, 0);
    push_exp(0, 3, 1'b0);
    for (int r = 0; r < 5; r++) begin
      send_bit(0, 1'b0, 1'b1, 1'b0);
      send_bit(0, 1'b1, 1'b1, r == 4);
    end
    req2 = '0;
    wait_done(1'b1);
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    req = 4'b0110;
    wait_grant(1'b0, 1);
    push_exp(1, 1, 1'b1);
    send_bit(1, 1'b0, 1'b1, 1'b0);
    send_bit(1, 1'b1, 1'b1, 1'b0);
    req[1] = 1'b0;
    wait_done(1'b0);
    wait_grant(1'b0, 2);
    push_exp(2, 0, 1'b0);
    send_bit(2, 1'b0, 1'b1, 1'b1);
    req = '0;
    wait_done(1'b0);
  endtask

`ifdef PDS_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int waited = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    req = 4'b1000;
    wait_grant(1'b0, 3);
    push_exp(3, 0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      waited = k + 1;
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got || waited != 16) begin
      n_err++; $display("FAIL timeout_cycles: done after %0d cycles (seen=%0d) required 16", waited, got);
    end
    n_cmp++;
    if ({aborted, match_count, done_id} !== {e.abrt, 8'(e.cnt), 2'(e.id)}) begin
      n_err++; $display("FAIL timeout_report: aborted=%0d count=%0d id=%0d required 1/0/3", aborted, match_count, done_id);
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_round_robin();
    test_gap();
    test_saturate();
    test_abort();
`ifdef PDS_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
